// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: FSM states, datapath control points
// and bit-period helper. Optional parity is enabled with UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_ONE  = 3'd1,
        SEL_ZERO = 3'd2,
        SEL_BIT  = 3'd3,
        SEL_PAR  = 3'd4
    } tx_sel_t;

    typedef struct packed {
        logic    load_shift;
        logic    shift_en;
        logic    clr_count;
        tx_sel_t tx_sel;
    } tx_ctrl_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Word handshake between a byte source and the UART transmitter.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_datapath.sv
// Bit-period counter, bit counter, shift register, parity and tx register.
// Parity generation exists only when UART_TX_PARITY_EN is defined.
module uart_tx_datapath
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  tx_ctrl_t              ctrl,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  tx,
    output logic                  bit_done,
    output logic [3:0]            bit_count
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    assign bit_done  = (clk_cnt_q == LAST_CLK);
    assign bit_count = bit_cnt_q;
    assign tx        = tx_q;

    always_comb begin
        clk_cnt_d = clk_cnt_q + CW'(1);
        if (ctrl.clr_count || bit_done) begin
            clk_cnt_d = '0;
        end

        bit_cnt_d = bit_cnt_q;
        if (ctrl.clr_count) begin
            bit_cnt_d = '0;
        end else if (ctrl.shift_en) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
        end

        shift_d = shift_q;
        if (ctrl.load_shift) begin
            shift_d = data;
        end else if (ctrl.shift_en) begin
            shift_d = shift_q >> 1;
        end

`ifdef UART_TX_PARITY_EN
        par_d = par_q;
        if (ctrl.load_shift) begin
            par_d = ^data;
        end
`endif

        // SEL_BIT takes the post-shift LSB so DATA drives the next bit
        case (ctrl.tx_sel)
            SEL_ONE:  tx_d = 1'b1;
            SEL_ZERO: tx_d = 1'b0;
            SEL_BIT:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            SEL_PAR:  tx_d = par_q;
`endif
            default:  tx_d = tx_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional even parity, stop bits.
// Define UART_TX_PARITY_EN to insert the even-parity bit after the data bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic     clock,
    input  logic     reset,
    uart_tx_if.slave bus,
    output logic     tx,
    output logic     tx_busy
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);
    localparam logic [3:0] LAST_STOP = 4'(DATA_WIDTH + PAR_BITS + STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_dw
        $error("uart_tx: DATA_WIDTH must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    tx_state_t  state_q, state_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    tx_ctrl_t   ctrl;
    logic       bit_done;
    logic [3:0] bit_count;

    assign bus.tx_ready = ready_q;
    assign tx_busy      = busy_q;

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        ctrl    = '{load_shift: 1'b0, shift_en: 1'b0,
                    clr_count: 1'b0, tx_sel: SEL_HOLD};
        unique case (state_q)
            IDLE: begin
                if (bus.tx_valid && ready_q) begin
                    ctrl.load_shift = 1'b1;
                    ctrl.clr_count  = 1'b1;
                    ctrl.tx_sel     = SEL_ZERO;
                    ready_d         = 1'b0;
                    busy_d          = 1'b1;
                    state_d         = START;
                end
            end
            START: begin
                if (bit_done) begin
                    ctrl.tx_sel = SEL_BIT;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    ctrl.shift_en = 1'b1;
                    if (bit_count == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                        ctrl.tx_sel = SEL_PAR;
                        state_d     = PARITY;
`else
                        ctrl.tx_sel = SEL_ONE;
                        state_d     = STOP;
`endif
                    end else begin
                        ctrl.tx_sel = SEL_BIT;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    ctrl.shift_en = 1'b1;
                    ctrl.tx_sel   = SEL_ONE;
                    state_d       = STOP;
                end
            end
`endif
            STOP: begin
                // bit_count keeps counting through stop bits to time the frame end
                if (bit_done) begin
                    ctrl.shift_en = 1'b1;
                    if (bit_count == LAST_STOP) begin
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                ctrl.tx_sel = SEL_ONE;
                ready_d     = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    uart_tx_datapath #(
        .DATA_WIDTH   (DATA_WIDTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_datapath (
        .clk       (clock),
        .rst_n     (reset),
        .ctrl      (ctrl),
        .data      (bus.tx_data),
        .tx        (tx),
        .bit_done  (bit_done),
        .bit_count (bit_count)
    );

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit, sampling on the falling edge.
// Parity scenarios are built in when UART_TX_PARITY_EN is defined.
module tb_uart_tx;
    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int N = NBITS * CPB;

    logic clock;
    logic reset;
    logic tx;
    logic tx_busy;
    int   n_checks;
    int   n_fail;

    uart_tx_if #(.DATA_WIDTH(8)) bus ();

    uart_tx #(
        .CLK_FREQ   (1_000_000),
        .BAUD_RATE  (100_000),
        .DATA_WIDTH (8),
        .STOP_BITS  (1)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic exp_tx(input logic [7:0] w, input logic par, input int k);
        int b;
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return w[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return par;
`endif
        return 1'b1;
    endfunction

    task automatic start(input logic [7:0] w, input bit hold);
        @(negedge clock);
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        n_checks++;
        if (bus.tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ready: got %b expected 1", bus.tx_ready);
        end
        @(posedge clock);
        @(negedge clock);
        if (!hold) bus.tx_valid = 1'b0;
    endtask

    // Entered at the first falling edge after acceptance; leaves at sample N.
    task automatic check_frame(input logic [7:0] w, input logic par, input string name);
        int         low;
        logic [7:0] rx;
        low = 0;
        rx  = '0;
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (tx !== exp_tx(w, par, k)) begin
                n_fail++;
                $display("FAIL %s tx@%0d: got %b expected %b",
                         name, k, tx, exp_tx(w, par, k));
            end
            if (bus.tx_ready === 1'b0 && tx_busy === 1'b1) low++;
            if (k % CPB == CPB / 2 && k / CPB >= 1 && k / CPB <= 8) rx[k/CPB-1] = tx;
            @(negedge clock);
        end
        n_checks++;
        if (low !== N) begin
            n_fail++;
            $display("FAIL %s busy_clocks: got %0d expected %0d", name, low, N);
        end
        n_checks++;
        if (rx !== w) begin
            n_fail++;
            $display("FAIL %s rx_word: got %h expected %h", name, rx, w);
        end
        n_checks++;
        if (bus.tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1) begin
            n_fail++;
            $display("FAIL %s end_idle: got ready=%b busy=%b tx=%b expected 1 0 1",
                     name, bus.tx_ready, tx_busy, tx);
        end
    endtask

    task automatic measure_gap(input string name);
        int hi;
        hi = CPB;
        while (tx === 1'b1 && hi < 4 * CPB) begin
            hi++;
            @(negedge clock);
        end
        n_checks++;
        if (hi !== CPB + 1) begin
            n_fail++;
            $display("FAIL %s stop_gap: got %0d expected %0d", name, hi, CPB + 1);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            n_checks++;
            if (tx !== 1'b1 || bus.tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle@%0d: got tx=%b ready=%b busy=%b expected 1 1 0",
                         i, tx, bus.tx_ready, tx_busy);
            end
        end
    endtask

    task automatic test_single();
        start(8'hA5, 1'b0);
        check_frame(8'hA5, 1'b0, "a5");
    endtask

    task automatic test_back_to_back();
        start(8'h00, 1'b1);
        bus.tx_data = 8'hFF;
        check_frame(8'h00, 1'b0, "b2b_00");
        measure_gap("b2b");
        bus.tx_valid = 1'b0;
        check_frame(8'hFF, 1'b0, "b2b_ff");
    endtask

    task automatic test_hold_data();
        start(8'h81, 1'b1);
        bus.tx_data = 8'h3C;
        check_frame(8'h81, 1'b0, "hold_81");
        measure_gap("hold");
        bus.tx_valid = 1'b0;
        check_frame(8'h3C, 1'b0, "hold_3c");
    endtask

    task automatic test_reset_mid();
        start(8'hF0, 1'b0);
        repeat (45) @(negedge clock);
        n_checks++;
        if (tx !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pre_reset_tx: got %b expected 0", tx);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1 || bus.tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_reset: got tx=%b ready=%b busy=%b expected 1 1 0",
                     tx, bus.tx_ready, tx_busy);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if (tx !== 1'b1 || bus.tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_after_release: got tx=%b ready=%b expected 1 1",
                     tx, bus.tx_ready);
        end
        start(8'h55, 1'b0);
        check_frame(8'h55, 1'b0, "post_reset_55");
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        start(8'h07, 1'b0);
        check_frame(8'h07, 1'b1, "par_07");
        start(8'h03, 1'b0);
        check_frame(8'h03, 1'b0, "par_03");
    endtask
`endif

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_data();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
